// File: rtl/ldtu_word_packer_pkg.sv
// Shared definitions for the LiTe-DTU output word packer: encoder state
// codes, state-class decode ranges, word header constants and packing helpers.
package ldtu_word_packer_pkg;

    // Encoder state codes shared with the TMR encoder FSM.
    localparam logic [4:0] ST_IDLE     = 5'd0;
    localparam logic [4:0] ST_BAS_A_LO = 5'd1;
    localparam logic [4:0] ST_BAS_A_HI = 5'd5;
    localparam logic [4:0] ST_SIG_A0   = 5'd6;
    localparam logic [4:0] ST_SIG_A1   = 5'd7;
    localparam logic [4:0] ST_BAS_B_LO = 5'd8;
    localparam logic [4:0] ST_BAS_B_HI = 5'd12;
    localparam logic [4:0] ST_SIG_B0   = 5'd13;
    localparam logic [4:0] ST_SIG_B1   = 5'd14;
    localparam logic [4:0] ST_BC0_LO   = 5'd15;
    localparam logic [4:0] ST_BC0_HI   = 5'd19;
    localparam logic [4:0] ST_HDR_0    = 5'd20;
    localparam logic [4:0] ST_HDR_1    = 5'd21;
    localparam logic [4:0] ST_BC0_S0   = 5'd22;
    localparam logic [4:0] ST_HDR_2    = 5'd23;
    localparam logic [4:0] ST_BC0_S1   = 5'd24;
    localparam logic [4:0] ST_ILL_LO   = 5'd25;

    // Word header fields.
    localparam logic [1:0] HDR_BAS_FULL = 2'b01;
    localparam logic [3:0] HDR_BAS_PART = 4'b1110;
    localparam logic [5:0] HDR_SIG_FULL = 6'b001010;
    localparam logic [5:0] HDR_SIG_PART = 6'b001011;
    localparam logic [3:0] HDR_FRAME    = 4'b1101;

    // Baseline geometry: five 6-bit samples per full word, four buffered.
    localparam int BAS_W     = 6;
    localparam int BAS_SLOTS = 4;

    typedef logic [BAS_SLOTS-1:0][BAS_W-1:0] bslots_t;

    // One-hot sample class of a state code.
    typedef enum logic [5:0] {
        CLS_IDLE = 6'b000001,
        CLS_BAS  = 6'b000010,
        CLS_SIG  = 6'b000100,
        CLS_BC0  = 6'b001000,
        CLS_HDR  = 6'b010000,
        CLS_ILL  = 6'b100000
    } cls_e;

    // Baseline partial word: the first n slots kept, the rest forced to zero.
    function automatic logic [31:0] pack_bas_partial(input bslots_t slots, input logic [2:0] n);
        bslots_t masked;
        for (int i = 0; i < BAS_SLOTS; i++) begin
            if (i < int'(n)) begin
                masked[i] = slots[i];
            end else begin
                masked[i] = 6'd0;
            end
        end
        return {HDR_BAS_PART, {1'b0, n}, masked};
    endfunction

    // Saturating increment for the word counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ldtu_word_packer_if.sv
// Sample-in / word-out bundle of the LiTe-DTU word packer.
interface ldtu_word_packer_if #(
    parameter int DW = 13,
    parameter int OW = 32
);
    logic [4:0]    state_in;
    logic [DW-1:0] data_in;
    logic [OW-1:0] DATA_out;
    logic          valid_out;
    logic          err_drop;
    logic          err_state;

    // Upstream encoder side / environment.
    modport master (
        output state_in,
        output data_in,
        input  DATA_out,
        input  valid_out,
        input  err_drop,
        input  err_state
    );

    // Packer side.
    modport slave (
        input  state_in,
        input  data_in,
        output DATA_out,
        output valid_out,
        output err_drop,
        output err_state
    );
endinterface

// File: rtl/ldtu_word_packer_state_class.sv
// Combinational decode of the voted encoder state code into a one-hot class.
module ldtu_state_class
    import ldtu_word_packer_pkg::*;
(
    input  logic [4:0] state_i,
    output cls_e       cls_o
);

    // Map every 5-bit code onto exactly one class; unused codes are illegal.
    always_comb begin
        cls_o = CLS_ILL;
        case (state_i)
            ST_IDLE: begin
                cls_o = CLS_IDLE;
            end
            ST_BAS_A_LO, 5'd2, 5'd3, 5'd4, ST_BAS_A_HI,
            ST_BAS_B_LO, 5'd9, 5'd10, 5'd11, ST_BAS_B_HI: begin
                cls_o = CLS_BAS;
            end
            ST_SIG_A0, ST_SIG_A1, ST_SIG_B0, ST_SIG_B1: begin
                cls_o = CLS_SIG;
            end
            ST_BC0_LO, 5'd16, 5'd17, 5'd18, ST_BC0_HI, ST_BC0_S0, ST_BC0_S1: begin
                cls_o = CLS_BC0;
            end
            ST_HDR_0, ST_HDR_1, ST_HDR_2: begin
                cls_o = CLS_HDR;
            end
            default: begin
                cls_o = CLS_ILL;
            end
        endcase
    end

endmodule

// File: rtl/ldtu_word_packer.sv
// LiTe-DTU output word packer: groups baseline samples five per word and
// signal samples two per word, flushes partial words on class changes and
// orbit markers, and inserts frame header words. One registered word out.
module ldtu_word_packer
    import ldtu_word_packer_pkg::*;
#(
    parameter int DW = 13,
    parameter int OW = 32
) (
    input  logic              CLK,
    input  logic              reset,
    ldtu_word_packer_if.slave bus
);

    cls_e cls_s;

    bslots_t       bbuf_q, bbuf_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [DW-1:0] sbuf_q, sbuf_d;
    logic          shalf_q, shalf_d;
    logic [7:0]    frame_q, frame_d;
    logic [15:0]   word_q, word_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;
    logic          estate_q, estate_d;

    ldtu_state_class u_class (
        .state_i (bus.state_in),
        .cls_o   (cls_s)
    );

    // Per-class packing decisions; at most one word is produced per cycle.
    always_comb begin
        bbuf_d   = bbuf_q;
        bcnt_d   = bcnt_q;
        sbuf_d   = sbuf_q;
        shalf_d  = shalf_q;
        frame_d  = frame_q;
        word_d   = word_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        drop_d   = 1'b0;
        estate_d = 1'b0;

        case (cls_s)
            CLS_BAS: begin
                // A pending signal half is closed out first; the baseline
                // buffer is necessarily empty then, so no full word collides.
                if (shalf_q) begin
                    data_d  = {HDR_SIG_PART, {DW{1'b0}}, sbuf_q};
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    shalf_d = 1'b0;
                end else begin
                    shalf_d = 1'b0;
                end
                if (bcnt_q == 3'd4) begin
                    data_d  = {HDR_BAS_FULL, bus.data_in[BAS_W-1:0], bbuf_q};
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    bcnt_d  = 3'd0;
                end else begin
                    bbuf_d[bcnt_q[1:0]] = bus.data_in[BAS_W-1:0];
                    bcnt_d              = bcnt_q + 3'd1;
                end
            end
            CLS_SIG: begin
                // A pending baseline partial is flushed; the signal buffer is
                // necessarily empty then, so the sample is only stored.
                if (bcnt_q != 3'd0) begin
                    data_d  = pack_bas_partial(bbuf_q, bcnt_q);
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    bcnt_d  = 3'd0;
                end else begin
                    bcnt_d  = 3'd0;
                end
                if (shalf_q) begin
                    data_d  = {HDR_SIG_FULL, bus.data_in, sbuf_q};
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    shalf_d = 1'b0;
                end else begin
                    sbuf_d  = bus.data_in;
                    shalf_d = 1'b1;
                end
            end
            CLS_BC0: begin
                // Orbit marker: flush whatever partial is pending; the sample
                // itself is re-presented by the upstream delay line.
                if (bcnt_q != 3'd0) begin
                    data_d  = pack_bas_partial(bbuf_q, bcnt_q);
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    bcnt_d  = 3'd0;
                end else if (shalf_q) begin
                    data_d  = {HDR_SIG_PART, {DW{1'b0}}, sbuf_q};
                    valid_d = 1'b1;
                    word_d  = sat_inc16(word_q);
                    shalf_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
            CLS_HDR: begin
                // Header wins the output slot; a pending partial is lost.
                data_d  = {HDR_FRAME, 4'b0000, frame_q, word_q};
                valid_d = 1'b1;
                frame_d = frame_q + 8'd1;
                word_d  = 16'd0;
                if ((bcnt_q != 3'd0) || shalf_q) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = 1'b0;
                end
                bcnt_d  = 3'd0;
                shalf_d = 1'b0;
            end
            CLS_IDLE: begin
                bcnt_d  = 3'd0;
                shalf_d = 1'b0;
            end
            default: begin
                bcnt_d   = 3'd0;
                shalf_d  = 1'b0;
                estate_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bbuf_q   <= '0;
            bcnt_q   <= 3'd0;
            sbuf_q   <= '0;
            shalf_q  <= 1'b0;
            frame_q  <= 8'd0;
            word_q   <= 16'd0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            estate_q <= 1'b0;
        end else begin
            bbuf_q   <= bbuf_d;
            bcnt_q   <= bcnt_d;
            sbuf_q   <= sbuf_d;
            shalf_q  <= shalf_d;
            frame_q  <= frame_d;
            word_q   <= word_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            estate_q <= estate_d;
        end
    end

    assign bus.DATA_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.err_drop  = drop_q;
    assign bus.err_state = estate_q;

endmodule

// File: tb/tb_ldtu_word_packer.sv
// Scoreboard bench for ldtu_word_packer: directed sample streams push the
// expected word/flag events; a negedge monitor pops and compares them.
module tb_ldtu_word_packer;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [31:0] data;
        logic        drop;
        logic        est;
    } exp_t;

    exp_t exp_q[$];

    ldtu_word_packer_if #(.DW(13), .OW(32)) bus ();

    ldtu_word_packer #(.DW(13), .OW(32)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of input and record the event expected after the edge.
    task automatic step(input logic [4:0] code, input logic [12:0] d,
                        input logic ev, input logic [31:0] ed,
                        input logic edrop, input logic est);
        exp_t e;
        @(negedge clk);
        bus.state_in = code;
        bus.data_in  = d;
        if (ev || edrop || est) begin
            e.cyc   = cyc + 1;
            e.valid = ev;
            e.data  = ed;
            e.drop  = edrop;
            e.est   = est;
            exp_q.push_back(e);
        end
    endtask

    task automatic quiet(input logic [4:0] code, input logic [12:0] d);
        step(code, d, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic word(input logic [4:0] code, input logic [12:0] d, input logic [31:0] ed);
        step(code, d, 1'b1, ed, 1'b0, 1'b0);
    endtask

    // Monitor: every observed word or error pulse must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.valid_out || bus.err_drop || bus.err_state)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d got valid=%b data=%h drop=%b est=%b, expected no output",
                         cyc, bus.valid_out, bus.DATA_out, bus.err_drop, bus.err_state);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.valid != bus.valid_out) ||
                    (e.valid && (e.data != bus.DATA_out)) ||
                    (e.drop != bus.err_drop) || (e.est != bus.err_state)) begin
                    failures++;
                    $display("FAIL output_event got cyc=%0d valid=%b data=%h drop=%b est=%b, expected cyc=%0d valid=%b data=%h drop=%b est=%b",
                             cyc, bus.valid_out, bus.DATA_out, bus.err_drop, bus.err_state,
                             e.cyc, e.valid, e.data, e.drop, e.est);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if ((bus.DATA_out !== 32'd0) || (bus.valid_out !== 1'b0) ||
            (bus.err_drop !== 1'b0) || (bus.err_state !== 1'b0)) begin
            failures++;
            $display("FAIL %s got data=%h valid=%b drop=%b est=%b, expected all zero",
                     name, bus.DATA_out, bus.valid_out, bus.err_drop, bus.err_state);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.state_in = 5'd0;
        bus.data_in  = 13'd0;
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Orbit sequence: signal half flushed by BC0, then two headers.
        quiet(5'd6, 13'd3);
        word(5'd22, 13'h1555, {6'b001011, 13'd0, 13'd3});
        word(5'd20, 13'h0AAA, {4'b1101, 4'b0000, 8'd0, 16'd1});
        word(5'd21, 13'h1FFF, {4'b1101, 4'b0000, 8'd1, 16'd0});

        // Full baseline words, plain and with high data bits set.
        quiet(5'd1, 13'd1);
        quiet(5'd2, 13'd2);
        quiet(5'd3, 13'd3);
        quiet(5'd4, 13'd4);
        word(5'd5, 13'd5, {2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
        quiet(5'd8, 13'h1FFF);
        quiet(5'd9, 13'h0AAA);
        quiet(5'd10, 13'h1555);
        quiet(5'd11, 13'h0040);
        word(5'd12, 13'h003F, {2'b01, 6'd63, 6'd0, 6'd21, 6'd42, 6'd63});

        // Full signal word.
        quiet(5'd6, 13'h1ABC);
        word(5'd7, 13'h0123, {6'b001010, 13'h0123, 13'h1ABC});

        // Class change flushes a baseline partial, then a full signal word.
        quiet(5'd1, 13'd7);
        quiet(5'd2, 13'd8);
        quiet(5'd3, 13'd9);
        word(5'd13, 13'h1FFF, {4'b1110, 4'd3, 6'd0, 6'd9, 6'd8, 6'd7});
        word(5'd14, 13'd5, {6'b001010, 13'd5, 13'h1FFF});

        // Signal half flushed by a baseline sample; that sample starts a word.
        quiet(5'd6, 13'h0777);
        word(5'd1, 13'd4, {6'b001011, 13'd0, 13'h0777});
        quiet(5'd2, 13'd5);
        quiet(5'd3, 13'd6);
        quiet(5'd4, 13'd7);
        word(5'd5, 13'd8, {2'b01, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4});

        // BC0 flushes a one-sample baseline partial; a second BC0 is silent.
        quiet(5'd1, 13'd33);
        word(5'd15, 13'h1234, {4'b1110, 4'd1, 6'd0, 6'd0, 6'd0, 6'd33});
        quiet(5'd16, 13'h0321);

        // Header reports eight data words in frame 2.
        word(5'd23, 13'd0, {4'b1101, 4'b0000, 8'd2, 16'd8});

        // Header with pending baseline partial, then pending signal half.
        quiet(5'd1, 13'd1);
        quiet(5'd2, 13'd2);
        step(5'd20, 13'd0, 1'b1, {4'b1101, 4'b0000, 8'd3, 16'd0}, 1'b1, 1'b0);
        quiet(5'd17, 13'd0);
        quiet(5'd7, 13'd9);
        step(5'd21, 13'd0, 1'b1, {4'b1101, 4'b0000, 8'd4, 16'd0}, 1'b1, 1'b0);

        // Illegal codes and IDLE clear the buffers without output.
        quiet(5'd8, 13'd10);
        step(5'd27, 13'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        quiet(5'd18, 13'd0);
        quiet(5'd9, 13'd11);
        quiet(5'd0, 13'd0);
        quiet(5'd19, 13'd0);
        step(5'd31, 13'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        word(5'd20, 13'd0, {4'b1101, 4'b0000, 8'd5, 16'd0});

        // Asynchronous reset in the middle of a baseline word.
        quiet(5'd1, 13'd21);
        quiet(5'd2, 13'd22);
        quiet(5'd3, 13'd23);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        bus.state_in = 5'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet(5'd10, 13'd1);
        quiet(5'd11, 13'd2);
        quiet(5'd12, 13'd3);
        quiet(5'd1, 13'd4);
        word(5'd2, 13'd5, {2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
        word(5'd21, 13'd0, {4'b1101, 4'b0000, 8'd0, 16'd1});

        // Frame counter wraps from 255 back to 0.
        for (int i = 1; i < 256; i++) begin
            word(5'd23, 13'd0, {4'b1101, 4'b0000, 8'(i), 16'd0});
        end
        word(5'd20, 13'd0, {4'b1101, 4'b0000, 8'd0, 16'd0});

        // Drain and confirm every expected event was observed.
        repeat (4) quiet(5'd0, 13'd0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_outputs got %0d events still pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
